// File: rtl/exec_muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit:
// funct3 operation encodings, FSM state codes and operand-signedness helpers.
package exec_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    // All divide/remainder ops have funct3[2] set.
    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // Remainder ops are the upper pair of the divide group.
    function automatic logic op_is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

    // rs1 is treated as two's complement for MUL, MULH, MULHSU, DIV, REM.
    function automatic logic rs1_is_signed(input logic [2:0] f);
        logic r;
        case (f)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    // rs2 is treated as two's complement for MUL, MULH, DIV, REM.
    function automatic logic rs2_is_signed(input logic [2:0] f);
        logic r;
        case (f)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_muldiv_unit_mdu_step.sv
// One radix-2 iteration of the iterative multiplier/divider.
// Multiply: {hi,lo} holds partial product and remaining multiplier bits;
//           opd is the multiplicand magnitude (shift-add, LSB first).
// Divide:   hi is the partial remainder, lo the dividend shifting out MSB
//           first while quotient bits shift in; opd is the divisor magnitude
//           (restoring subtraction).
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN-1:0] diff_s;
    logic            fits_s;

    // Single shift-add or restoring-subtract step selected by operation class.
    always_comb begin
        sum_s     = {1'b0, hi_i} + {1'b0, opd_i};
        shifted_s = {hi_i, lo_i[XLEN-1]};
        fits_s    = (shifted_s >= {1'b0, opd_i});
        // When the divisor fits, the true difference is below 2^XLEN,
        // so the wrapped XLEN-bit subtraction is exact.
        diff_s    = shifted_s[XLEN-1:0] - opd_i;
        hi_o      = hi_i;
        lo_o      = lo_i;
        if (is_div_i) begin
            if (fits_s) begin
                hi_o = diff_s;
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shifted_s[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            if (lo_i[0]) begin
                {hi_o, lo_o} = {sum_s, lo_i[XLEN-1:1]};
            end else begin
                {hi_o, lo_o} = {1'b0, hi_i, lo_i[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Operands are converted to magnitudes on accept, processed one bit per
// cycle by mdu_step, and sign-corrected when the last step completes.
// Divide-by-zero and signed overflow finish in a single cycle.
module exec_muldiv_unit
    import exec_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [RD_W-1:0] rd_addr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd_addr,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sgn1_s, sgn2_s;
    logic [XLEN-1:0] mag1_s, mag2_s;
    logic            div_zero_s, div_ovf_s;
    logic [XLEN-1:0] special_s;
    logic [XLEN-1:0] hi_step_s, lo_step_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic [XLEN-1:0] quo_fix_s, rem_fix_s, final_s;

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opd_i    (opd_q),
        .hi_o     (hi_step_s),
        .lo_o     (lo_step_s)
    );

    // Incoming operand signs, magnitudes and single-cycle special cases.
    always_comb begin
        sgn1_s     = rs1_is_signed(funct3) & rs1[XLEN-1];
        sgn2_s     = rs2_is_signed(funct3) & rs2[XLEN-1];
        mag1_s     = sgn1_s ? -rs1 : rs1;
        mag2_s     = sgn2_s ? -rs2 : rs2;
        div_zero_s = op_is_div(funct3) && (rs2 == {XLEN{1'b0}});
        div_ovf_s  = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                     (rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (rs2 == {XLEN{1'b1}});
        if (div_zero_s) begin
            special_s = op_is_rem(funct3) ? rs1 : {XLEN{1'b1}};
        end else begin
            special_s = op_is_rem(funct3) ? {XLEN{1'b0}} : rs1;
        end
    end

    // Sign fix-up of the value produced by the final iteration.
    always_comb begin
        prod_s     = {hi_step_s, lo_step_s};
        prod_fix_s = neg_q ? -prod_s : prod_s;
        quo_fix_s  = neg_q ? -lo_step_s : lo_step_s;
        rem_fix_s  = rneg_q ? -hi_step_s : hi_step_s;
        if (op_is_div(op_q)) begin
            final_s = op_is_rem(op_q) ? rem_fix_s : quo_fix_s;
        end else if (op_q == OP_MUL) begin
            final_s = prod_fix_s[XLEN-1:0];
        end else begin
            final_s = prod_fix_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic: flush wins in every state, then IDLE/CALC/DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d   = funct3;
                        rd_d   = rd_addr;
                        neg_d  = sgn1_s ^ sgn2_s;
                        rneg_d = sgn1_s;
                        hi_d   = {XLEN{1'b0}};
                        if (div_zero_s || div_ovf_s) begin
                            result_d = special_s;
                            cnt_d    = {CNT_W{1'b0}};
                            state_d  = ST_DONE;
                        end else begin
                            cnt_d   = CNT_W'(XLEN - 1);
                            state_d = ST_CALC;
                            if (op_is_div(funct3)) begin
                                lo_d  = mag1_s;
                                opd_d = mag2_s;
                            end else begin
                                lo_d  = mag2_s;
                                opd_d = mag1_s;
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    hi_d = hi_step_s;
                    lo_d = lo_step_s;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        result_d = final_s;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and result registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 3'b000;
            rd_q     <= {RD_W{1'b0}};
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            opd_q    <= {XLEN{1'b0}};
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_result  = result_q;
    assign out_rd_addr = rd_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Self-checking bench for exec_muldiv_unit (XLEN=32): directed vector table,
// randomized ops against an arithmetic reference model, and handshake,
// flush and reset sequences.
module tb_exec_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd_addr;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs [15];

    exec_muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd_addr     (rd_addr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd_addr (out_rd_addr),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called right after the accepting posedge; counts negedges until out_valid.
    task automatic wait_result(output logic [31:0] res, output logic [4:0] rdo, output int lat);
        lat = 0;
        res = 32'd0;
        rdo = 5'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = k;
                res = out_result;
                rdo = out_rd_addr;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output int lat);
        @(negedge clk);
        funct3    = f;
        rs1       = a;
        rs2       = b;
        rd_addr   = rd;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        wait_result(res, rdo, lat);
    endtask

    initial begin
        logic [31:0] res, a, b;
        logic [4:0]  rdo, rd;
        logic [2:0]  f;
        int          lat, sel;
        logic        seen;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 8'd33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 8'd33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        8'd33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         8'd33};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 8'd1};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         8'd1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         8'd1};
        vecs[12] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         8'd33};
        vecs[13] = '{3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF, 8'd1};
        vecs[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         8'd33};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        funct3    = 3'd0;
        rs1       = 32'd0;
        rs2       = 32'd0;
        rd_addr   = 5'd0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd_addr, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), res, rdo, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_rd", i), rdo, 5'(i + 1));
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 5);
            a   = $urandom;
            b   = $urandom;
            rd  = 5'($urandom_range(0, 31));
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                b = 32'($urandom_range(1, 20));
            end else if (sel == 3) begin
                a = 32'($urandom_range(0, 1000));
                b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
            end
            run_op(f, a, b, rd, res, rdo, lat);
            chk($sformatf("rand%0d_f%0d_result", i, f), res, ref_result(f, a, b));
            chk($sformatf("rand%0d_f%0d_latency", i, f), lat, ref_latency(f, a, b));
            chk($sformatf("rand%0d_rd", i), rdo, rd);
        end

        // Flush at cycle 10 of a divide
        @(negedge clk);
        funct3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd12;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (k == 1) chk("flush_busy_before", busy, 1);
            if (k == 9) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", seen, 0);

        // Request together with flush is not accepted
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6; rd_addr = 5'd4;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flushreq_busy", busy, 0);
        chk("flushreq_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (36) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flushreq_no_result", seen, 0);

        // Hold in DONE with out_ready low, then release with a waiting request
        @(negedge clk);
        funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd9;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("hold_reach_done", seen, 1);
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd_addr = 5'd3;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
            chk($sformatf("hold%0d_result", k), out_result, 32'd14);
            chk($sformatf("hold%0d_rd", k), out_rd_addr, 5'd9);
            chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        @(posedge clk);
        wait_result(res, rdo, lat);
        chk("after_release_result", res, 32'd12);
        chk("after_release_latency", lat, 33);
        chk("after_release_rd", rdo, 5'd3);

        // Reset in the middle of an operation
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_addr = 5'd17;
        in_valid = 1'b1;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("midop_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_result", out_result, 0);
        chk("midrst_out_rd", out_rd_addr, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", seen, 0);
        chk("midrst_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exec_muldiv_unit.md
EXEC_MULDIV_UNIT -- requirements
Module: exec_muldiv_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand and result width (>=8, even).
REQ-002 SHALL provide parameter RD_W, default 5, destination register address width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  M-op request present.
REQ-006 SHALL have port in_ready  output  1  unit idle, request accepted when in_valid&in_ready.
REQ-007 SHALL have port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have ports rs1, rs2  input  XLEN  forwarded operands.
REQ-009 SHALL have port rd_addr  input  RD_W  destination tag.
REQ-010 SHALL have port flush  input  1  abort in-flight op.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have ports out_result  output  XLEN, out_rd_addr  output  RD_W.
REQ-014 SHALL have port busy  output  1  state != IDLE, drives pipeline stall.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 IDLE: in_ready=1; on accept latch funct3, rd_addr, operand magnitudes, sign flags; go CALC with counter=XLEN-1, or DONE directly for special cases.
REQ-017 CALC: one radix-2 step per cycle (shift-add for MUL*, restoring subtract for DIV*/REM*); counter decrements; at counter 0 go DONE, registering sign-corrected result.
REQ-018 Normal latency SHALL be XLEN+1 cycles: accept edge N, out_valid high from cycle N+XLEN+1.
REQ-019 DONE: out_valid=1, out_result/out_rd_addr stable; on out_ready go IDLE; hold otherwise.
REQ-020 Signedness: MUL/MULH/DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; *U unsigned.
REQ-021 MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN] of full 2*XLEN product.
REQ-022 Remainder sign SHALL follow dividend; quotient truncates toward zero.
REQ-023 Divide by zero: quotient all ones, remainder = rs1; latency 1 cycle (DONE next cycle).
REQ-024 Signed overflow (rs1=most negative, rs2=-1, DIV/REM): quotient = rs1, remainder 0; latency 1 cycle.
REQ-025 flush SHALL take precedence in every state: next state IDLE, out_valid low next cycle, result discarded.
REQ-026 in_valid with flush in same cycle SHALL NOT be accepted.
REQ-027 in_valid while busy SHALL be ignored; requester holds until in_ready.
REQ-028 out_ready in DONE with new in_valid same cycle: return to IDLE, new op accepted next cycle (no back-to-back bypass).

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, counter 0, out_valid 0, out_result 0, out_rd_addr 0, busy 0; in_ready 1 after release.
REQ-030 Reset mid-operation SHALL discard op without emitting out_valid.

Structure
REQ-031 funct3 M-op encodings and FSM state codes SHALL live in shared defs.v alongside existing branch/forward selects.
REQ-032 One combinational sub-module mdu_step SHALL implement a single shift-add/subtract iteration; FSM, counter, sign fix-up in top.

Verification
REQ-033 MUL rs1=7, rs2=0xFFFFFFFD (-3) -> out_result 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-034 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-036 DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each out_valid 1 cycle after accept.
REQ-037 flush at cycle 10 of DIV -> no out_valid, in_ready=1 next cycle; rst_n low at cycle 5 -> outputs zero immediately.
REQ-038 out_ready held low 4 cycles in DONE -> out_result/out_rd_addr stable, in_ready stays 0 until release.
